// File: rtl/sw_array_ctrl_if.sv
// Handshake and PE-array signals of the alignment sequencer.
// valid/ready: a transfer happens on a rising edge where both are high; valid may rise without waiting for ready.
interface sw_array_ctrl_if #(
    parameter int N_PE    = 8,
    parameter int SCORE_W = 8
);
    logic                    qry_valid;
    logic [2:0]              qry_base;
    logic                    qry_ready;
    logic                    ref_valid;
    logic [2:0]              ref_base;
    logic                    ref_ready;
    logic                    arr_clr;
    logic                    arr_en;
    logic [2:0]              arr_ref_base;
    logic [3*N_PE-1:0]       arr_qry;
    logic [SCORE_W*N_PE-1:0] arr_score;

    modport master (
        input  qry_valid, qry_base, ref_valid, ref_base, arr_score,
        output qry_ready, ref_ready, arr_clr, arr_en, arr_ref_base, arr_qry
    );

    modport slave (
        output qry_valid, qry_base, ref_valid, ref_base, arr_score,
        input  qry_ready, ref_ready, arr_clr, arr_en, arr_ref_base, arr_qry
    );
endinterface

// File: rtl/sw_array_ctrl.sv
// Sequencer for a linear Smith-Waterman PE array: loads the query, streams the reference
// as wavefront steps, drains the wavefront and tracks the best cell and its coordinates.
module sw_array_ctrl #(
    parameter int  N_PE    = 8,
    parameter int  REF_MAX = 64,
    parameter int  SCORE_W = 8,
    localparam int QW      = $clog2(N_PE + 1),
    localparam int RW      = $clog2(REF_MAX + 1),
    localparam int QPW     = $clog2(N_PE),
    localparam int RPW     = $clog2(REF_MAX)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [QW-1:0]        qry_len,
    input  logic [RW-1:0]        ref_len,
    sw_array_ctrl_if.master      bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [SCORE_W-1:0]   best_score,
    output logic [QPW-1:0]       best_qpos,
    output logic [RPW-1:0]       best_rpos,
    output logic [2:0]           state_dbg
);
    localparam int TW = RW + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_Q = 3'd1;
    localparam logic [2:0] S_CLEAR  = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_FLUSH  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic [2:0]            state;
    logic [QW-1:0]         q_r, k, dc;
    logic [RW-1:0]         r_r, rc;
    logic [TW-1:0]         t, t_d;
    logic                  en_d, err_flag, rst_flag;
    logic [N_PE-1:0][2:0]  qry_r;
    logic                  stream_hs, bad_req;
    logic [SCORE_W-1:0]    cand_score;
    logic [QPW-1:0]        cand_q;
    logic [RPW-1:0]        cand_r;
    logic                  hit;
    int                    diff;

    assign stream_hs        = (state == S_STREAM) && bus.ref_valid;
    assign bad_req          = (qry_len == '0) || (qry_len > QW'(N_PE)) || (ref_len == '0);
    assign bus.qry_ready    = (state == S_LOAD_Q);
    assign bus.ref_ready    = (state == S_STREAM);
    assign bus.arr_clr      = rst_flag || (state == S_CLEAR);
    assign bus.arr_en       = stream_hs || (state == S_DRAIN);
    assign bus.arr_ref_base = stream_hs ? bus.ref_base : ((state == S_DRAIN) ? 3'b111 : 3'b000);
    assign bus.arr_qry      = qry_r;
    assign busy             = (state != S_IDLE);
    assign done             = (state == S_DONE);
    assign err              = done && err_flag;
    assign state_dbg        = state;

    // Scores of step t_d: strict '>' in ascending PE order keeps the lowest i on ties
    // and, against the running best, keeps the earlier step.
    always_comb begin
        cand_score = best_score;
        cand_q     = best_qpos;
        cand_r     = best_rpos;
        hit        = 1'b0;
        diff       = 0;
        for (int i = 0; i < N_PE; i++) begin
            diff = int'(t_d) - i;
            if (i < int'(q_r) && diff >= 0 && diff < int'(r_r) &&
                bus.arr_score[SCORE_W*i +: SCORE_W] > cand_score) begin
                cand_score = bus.arr_score[SCORE_W*i +: SCORE_W];
                cand_q     = QPW'(i);
                cand_r     = RPW'(diff);
                hit        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            rst_flag   <= 1'b1;
            q_r        <= '0;
            r_r        <= '0;
            k          <= '0;
            rc         <= '0;
            dc         <= '0;
            t          <= '0;
            t_d        <= '0;
            en_d       <= 1'b0;
            err_flag   <= 1'b0;
            qry_r      <= {N_PE{3'b111}};
            best_score <= '0;
            best_qpos  <= '0;
            best_rpos  <= '0;
        end else begin
            rst_flag <= 1'b0;
            en_d     <= bus.arr_en;
            t_d      <= t;
            if (bus.arr_en) t <= t + TW'(1);
            if (en_d && hit) begin
                best_score <= cand_score;
                best_qpos  <= cand_q;
                best_rpos  <= cand_r;
            end
            case (state)
                S_IDLE: if (start) begin
                    q_r        <= qry_len;
                    r_r        <= ref_len;
                    k          <= '0;
                    qry_r      <= {N_PE{3'b111}};
                    best_score <= '0;
                    best_qpos  <= '0;
                    best_rpos  <= '0;
                    err_flag   <= bad_req;
                    state      <= bad_req ? S_DONE : S_LOAD_Q;
                end
                S_LOAD_Q: if (bus.qry_valid) begin
                    qry_r[k[QPW-1:0]] <= bus.qry_base;
                    if (bus.qry_base == 3'b111) err_flag <= 1'b1;
                    k <= k + QW'(1);
                    if (k == q_r - QW'(1)) state <= S_CLEAR;
                end
                S_CLEAR: begin
                    t     <= '0;
                    rc    <= '0;
                    state <= S_STREAM;
                end
                S_STREAM: if (bus.ref_valid) begin
                    rc <= rc + RW'(1);
                    dc <= '0;
                    if (rc == r_r - RW'(1)) state <= (q_r == QW'(1)) ? S_FLUSH : S_DRAIN;
                end
                S_DRAIN: begin
                    dc <= dc + QW'(1);
                    if (dc == q_r - QW'(2)) state <= S_FLUSH;
                end
                S_FLUSH: state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sw_array_ctrl.sv
// Directed bench for sw_array_ctrl with a behavioural Smith-Waterman array model
// that drives arr_score (junk values in cells outside the alignment window).
module tb_sw_array_ctrl;
    localparam int N_PE = 8, REF_MAX = 64, SCORE_W = 8;
    localparam int QW = $clog2(N_PE + 1), RW = $clog2(REF_MAX + 1);
    localparam int QPW = $clog2(N_PE), RPW = $clog2(REF_MAX);
    localparam logic [7:0] JUNK = 8'd200;

    logic clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic [QW-1:0] qry_len = '0;
    logic [RW-1:0] ref_len = '0;
    logic busy, done, err;
    logic [SCORE_W-1:0] best_score;
    logic [QPW-1:0] best_qpos;
    logic [RPW-1:0] best_rpos;
    logic [2:0] state_dbg;
    logic [3*N_PE-1:0] all_pad;

    int vectors = 0, miscompares = 0;

    sw_array_ctrl_if #(.N_PE(N_PE), .SCORE_W(SCORE_W)) bus ();

    sw_array_ctrl #(.N_PE(N_PE), .REF_MAX(REF_MAX), .SCORE_W(SCORE_W)) dut (
        .clk(clk), .reset(reset), .start(start), .qry_len(qry_len), .ref_len(ref_len),
        .bus(bus), .busy(busy), .done(done), .err(err), .best_score(best_score),
        .best_qpos(best_qpos), .best_rpos(best_rpos), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Array model: step t computes cell (i, t-i) of the DP matrix in every PE.
    int hm [N_PE][80];
    logic [2:0] refb [80];
    int step, mj, mv, md, mu, ml, ms;
    logic [2:0] mqb;
    logic [SCORE_W*N_PE-1:0] nxt_score;
    always @(posedge clk) begin
        if (!reset || bus.arr_clr) begin
            step = 0;
            bus.arr_score <= '0;
        end else if (bus.arr_en) begin
            refb[step] = bus.arr_ref_base;
            nxt_score = '0;
            for (int i = 0; i < N_PE; i++) begin
                mj  = step - i;
                mqb = bus.arr_qry[3*i +: 3];
                if (mj < 0) nxt_score[SCORE_W*i +: SCORE_W] = JUNK;
                else if (refb[mj] == 3'b111) nxt_score[SCORE_W*i +: SCORE_W] = JUNK;
                else begin
                    md = (i > 0 && mj > 0) ? hm[i-1][mj-1] : 0;
                    mu = (i > 0) ? hm[i-1][mj] : 0;
                    ml = (mj > 0) ? hm[i][mj-1] : 0;
                    ms = (mqb == refb[mj] && mqb != 3'b111) ? 2 : -1;
                    mv = 0;
                    if (md + ms > mv) mv = md + ms;
                    if (mu - 1 > mv) mv = mu - 1;
                    if (ml - 1 > mv) mv = ml - 1;
                    hm[i][mj] = mv;
                    nxt_score[SCORE_W*i +: SCORE_W] = SCORE_W'(mv);
                end
            end
            bus.arr_score <= nxt_score;
            step = step + 1;
        end
    end

    // Stimulus state and per-run observations
    logic [2:0] qseq [8];
    logic [2:0] rseq [16];
    int q_n, r_n, qi, ri, cyc;
    int stall_after = -1, stall_len = 0, stall_left = 0, start_pulse_cyc = -1;
    int done_cyc, done_cnt, en_cnt, qready_cnt, stall_en_bad;
    logic err_at_done;

    task automatic set_q(input int n, input logic [23:0] v);
        q_n = n;
        for (int i = 0; i < 8; i++) qseq[i] = v[3*i +: 3];
    endtask

    task automatic set_r(input int n, input logic [47:0] v);
        r_n = n;
        for (int i = 0; i < 16; i++) rseq[i] = v[3*i +: 3];
    endtask

    task automatic begin_run(input int ql, input int rl);
        @(negedge clk);
        cyc = 0; qi = 0; ri = 0; stall_left = 0;
        done_cyc = -1; done_cnt = 0; en_cnt = 0; qready_cnt = 0; stall_en_bad = 0;
        err_at_done = 1'b0;
        qry_len = QW'(ql);
        ref_len = RW'(rl);
        start = 1'b1;
        bus.qry_valid = 1'b0;
        bus.ref_valid = 1'b0;
    endtask

    task automatic tick();
        logic in_stall;
        @(negedge clk);
        cyc++;
        start = (cyc == start_pulse_cyc);
        bus.qry_valid = (qi < q_n);
        bus.qry_base  = (qi < q_n) ? qseq[qi] : 3'b000;
        in_stall = 1'b0;
        if (bus.ref_ready && stall_left > 0) begin
            stall_left--;
            in_stall = 1'b1;
        end
        bus.ref_valid = (ri < r_n) && !in_stall;
        bus.ref_base  = (ri < r_n) ? rseq[ri] : 3'b000;
        #1;
        if (bus.qry_ready) qready_cnt++;
        if (bus.qry_ready && bus.qry_valid) qi++;
        if (bus.ref_ready && bus.ref_valid) begin
            ri++;
            if (ri == stall_after) stall_left = stall_len;
        end
        if (bus.arr_en) en_cnt++;
        if (in_stall && bus.arr_en) stall_en_bad++;
        if (done) begin
            done_cnt++;
            if (done_cyc < 0) begin done_cyc = cyc; err_at_done = err; end
        end
    endtask

    task automatic run(input int ql, input int rl);
        begin_run(ql, rl);
        while (done_cyc < 0 && cyc < 200) tick();
        if (done_cyc < 0) begin
            vectors++; miscompares++;
            $display("FAIL run_timeout: no done within %0d cycles", cyc);
        end
        repeat (3) tick();
        start_pulse_cyc = -1; stall_after = -1; stall_len = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        vectors++; if (bus.arr_clr !== 1'b1) begin miscompares++; $display("FAIL rst_arr_clr: got %b want 1", bus.arr_clr); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
        vectors++; if ({done, err} !== 2'b00) begin miscompares++; $display("FAIL rst_done_err: got %b want 00", {done, err}); end
        vectors++; if ({best_score, best_qpos, best_rpos} !== '0) begin miscompares++; $display("FAIL rst_best: got %0d/%0d/%0d want 0/0/0", best_score, best_qpos, best_rpos); end
        vectors++; if (bus.arr_qry !== all_pad) begin miscompares++; $display("FAIL rst_arr_qry: got %h want %h", bus.arr_qry, all_pad); end
        vectors++; if ({bus.qry_ready, bus.ref_ready, bus.arr_en, bus.arr_ref_base} !== 6'b0) begin miscompares++; $display("FAIL rst_handshake: got %b want 0", {bus.qry_ready, bus.ref_ready, bus.arr_en, bus.arr_ref_base}); end
        reset = 1'b1;
        @(negedge clk); #1;
        vectors++; if (bus.arr_clr !== 1'b0) begin miscompares++; $display("FAIL rst_release_clr: got %b want 0", bus.arr_clr); end
    endtask

    task automatic check_result(input string name, input int dcyc, input int ens, input logic e,
                                input int bs, input int bq, input int br);
        vectors++; if (done_cyc != dcyc) begin miscompares++; $display("FAIL %s_done_cycle: got %0d want %0d", name, done_cyc, dcyc); end
        vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL %s_done_pulses: got %0d want 1", name, done_cnt); end
        vectors++; if (en_cnt != ens) begin miscompares++; $display("FAIL %s_arr_en_cycles: got %0d want %0d", name, en_cnt, ens); end
        vectors++; if (err_at_done !== e) begin miscompares++; $display("FAIL %s_err: got %b want %b", name, err_at_done, e); end
        vectors++; if (best_score !== SCORE_W'(bs)) begin miscompares++; $display("FAIL %s_best_score: got %0d want %0d", name, best_score, bs); end
        vectors++; if (best_qpos !== QPW'(bq) || best_rpos !== RPW'(br)) begin miscompares++; $display("FAIL %s_best_pos: got (%0d,%0d) want (%0d,%0d)", name, best_qpos, best_rpos, bq, br); end
    endtask

    task automatic test_match();
        set_q(4, {12'h0, 3'd3, 3'd2, 3'd1, 3'd0});
        set_r(4, {36'h0, 3'd3, 3'd2, 3'd1, 3'd0});
        run(4, 4);
        check_result("match", 14, 7, 1'b0, 8, 3, 3);
        vectors++; if (qready_cnt != 4) begin miscompares++; $display("FAIL match_qry_ready_cycles: got %0d want 4", qready_cnt); end
    endtask

    task automatic test_mismatch();
        set_q(4, 24'h0);
        set_r(4, {36'h0, 3'd1, 3'd1, 3'd1, 3'd1});
        run(4, 4);
        check_result("mismatch", 14, 7, 1'b0, 0, 0, 0);
    endtask

    task automatic test_stall();
        set_q(4, {12'h0, 3'd3, 3'd2, 3'd1, 3'd0});
        set_r(4, {36'h0, 3'd3, 3'd2, 3'd1, 3'd0});
        stall_after = 2; stall_len = 3;
        run(4, 4);
        check_result("stall", 17, 7, 1'b0, 8, 3, 3);
        vectors++; if (stall_en_bad != 0) begin miscompares++; $display("FAIL stall_arr_en: got %0d enabled stall cycles want 0", stall_en_bad); end
    endtask

    task automatic test_error();
        int ql [3] = '{0, 4, 9};
        int rl [3] = '{4, 0, 4};
        for (int n = 0; n < 3; n++) begin
            set_q(ql[n] > 8 ? 0 : ql[n], {12'h0, 3'd3, 3'd2, 3'd1, 3'd0});
            set_r(rl[n], {36'h0, 3'd3, 3'd2, 3'd1, 3'd0});
            run(ql[n], rl[n]);
            vectors++; if (done_cyc != 1 || err_at_done !== 1'b1) begin miscompares++; $display("FAIL error%0d_done_err: got cycle %0d err %b want cycle 1 err 1", n, done_cyc, err_at_done); end
            vectors++; if (qready_cnt != 0) begin miscompares++; $display("FAIL error%0d_qry_ready: got %0d cycles want 0", n, qready_cnt); end
            vectors++; if (best_score !== '0) begin miscompares++; $display("FAIL error%0d_best_score: got %0d want 0", n, best_score); end
            vectors++; if (en_cnt != 0) begin miscompares++; $display("FAIL error%0d_arr_en: got %0d want 0", n, en_cnt); end
        end
    endtask

    task automatic test_partial();
        logic [3*N_PE-1:0] exp_qry;
        exp_qry = {{5{3'b111}}, 3'd3, 3'd2, 3'd1};
        set_q(3, {15'h0, 3'd3, 3'd2, 3'd1});
        set_r(5, {33'h0, 3'd1, 3'd3, 3'd2, 3'd1, 3'd0});
        run(3, 5);
        check_result("partial", 13, 7, 1'b0, 6, 2, 3);
        vectors++; if (bus.arr_qry !== exp_qry) begin miscompares++; $display("FAIL partial_arr_qry: got %h want %h", bus.arr_qry, exp_qry); end
    endtask

    task automatic test_ties();
        set_q(2, {18'h0, 3'd1, 3'd0});
        set_r(2, {42'h0, 3'd0, 3'd1});
        run(2, 2);
        check_result("ties", 8, 3, 1'b0, 2, 0, 1);
    endtask

    task automatic test_bad_base();
        set_q(2, {18'h0, 3'd0, 3'd7});
        set_r(2, {42'h0, 3'd0, 3'd0});
        run(2, 2);
        check_result("bad_base", 8, 3, 1'b1, 2, 1, 0);
    endtask

    task automatic test_q1();
        set_q(1, {21'h0, 3'd2});
        set_r(3, {39'h0, 3'd2, 3'd2, 3'd1});
        run(1, 3);
        check_result("q1", 7, 3, 1'b0, 2, 0, 1);
    endtask

    task automatic test_reset_mid();
        set_q(4, {12'h0, 3'd3, 3'd2, 3'd1, 3'd0});
        set_r(4, {36'h0, 3'd3, 3'd2, 3'd1, 3'd0});
        begin_run(4, 4);
        repeat (8) tick();
        vectors++; if (busy !== 1'b1 || best_score !== 8'd2) begin miscompares++; $display("FAIL mid_pre_reset: got busy %b best %0d want busy 1 best 2", busy, best_score); end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        bus.qry_valid = 1'b0;
        bus.ref_valid = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0 || bus.arr_clr !== 1'b1) begin miscompares++; $display("FAIL mid_reset_state: got busy %b arr_clr %b want 0 1", busy, bus.arr_clr); end
        vectors++; if (best_score !== '0 || done !== 1'b0) begin miscompares++; $display("FAIL mid_reset_best: got best %0d done %b want 0 0", best_score, done); end
        vectors++; if (bus.arr_qry !== all_pad) begin miscompares++; $display("FAIL mid_reset_arr_qry: got %h want %h", bus.arr_qry, all_pad); end
        @(negedge clk); #1;
        vectors++; if (bus.arr_clr !== 1'b0) begin miscompares++; $display("FAIL mid_release_clr: got %b want 0", bus.arr_clr); end
        run(4, 4);
        check_result("after_reset", 14, 7, 1'b0, 8, 3, 3);
    endtask

    task automatic test_start_in_drain();
        set_q(4, {12'h0, 3'd3, 3'd2, 3'd1, 3'd0});
        set_r(4, {36'h0, 3'd3, 3'd2, 3'd1, 3'd0});
        start_pulse_cyc = 11;
        run(4, 4);
        check_result("drain_start", 14, 7, 1'b0, 8, 3, 3);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL drain_start_idle: got busy %b want 0", busy); end
    endtask

    initial begin
        all_pad = {N_PE{3'b111}};
        bus.qry_valid = 1'b0; bus.qry_base = '0;
        bus.ref_valid = 1'b0; bus.ref_base = '0;
        test_reset();
        test_match();
        test_mismatch();
        test_stall();
        test_error();
        test_partial();
        test_ties();
        test_bad_base();
        test_q1();
        test_reset_mid();
        test_start_in_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sw_array_ctrl.md
# sw_array_ctrl

Sequencer for the linear systolic array of alignment PEs (score match +2, mismatch −1, gap −1, floor 0). It loads a query of up to N_PE bases into the array (one base per PE), clears the array, and streams reference bases into PE0 one wavefront step at a time. It then drains the wavefront and tracks the best cell score and its (query, reference) coordinates. It sits between the read/reference fetch logic and the PE array wrapper.

## Interface
- N_PE, 8, number of PEs in the array (max query length)
- REF_MAX, 64, max reference length
- SCORE_W, 8, PE score width
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- start  in  1  begin alignment; sampled only in IDLE
- qry_len  in  clog2(N_PE+1)  query length, legal 1..N_PE
- ref_len  in  clog2(REF_MAX+1)  reference length, legal 1..REF_MAX
- qry_valid / qry_base[2:0] / qry_ready  in/in/out  query load handshake
- ref_valid / ref_base[2:0] / ref_ready  in/in/out  reference stream handshake
- arr_clr  out  1  array clear (PEs zero their score registers)
- arr_en  out  1  array advances one wavefront step this cycle
- arr_ref_base  out  3  base presented to PE0 on an arr_en cycle
- arr_qry  out  3*N_PE  per-PE query base; unused PEs hold 3'b111
- arr_score  in  SCORE_W*N_PE  registered score of each PE
- busy, done, err  out  1 each  status; done and err are 1-cycle pulses
- best_score  out  SCORE_W  maximum score found
- best_qpos, best_rpos  out  clog2(N_PE), clog2(REF_MAX)  coordinates of best_score

## Operation
- States: IDLE → LOAD_Q → CLEAR → STREAM → DRAIN → FLUSH → DONE → IDLE.
- IDLE: on start, latch Q=qry_len and R=ref_len, zero the best registers, and go to LOAD_Q. If Q=0, Q>N_PE, or R=0, go to DONE with err=1 and no load.
- LOAD_Q: qry_ready=1. Each handshake writes qry_base into PE slot k, then increments k. After the Q-th handshake, go to CLEAR. A qry_base of 3'b111 sets a sticky error flag; the run completes and err pulses with done.
- CLEAR: arr_clr=1 for exactly one cycle, then go to STREAM.
- STREAM: ref_ready=1. On each handshake: arr_en=1, arr_ref_base=ref_base, step counter t increments. With no handshake, arr_en=0 and the array holds. After the R-th handshake, go to DRAIN, or to FLUSH if Q=1.
- DRAIN: arr_en=1 every cycle, with arr_ref_base=3'b111 (pad, never matches). Runs for exactly Q−1 cycles, then goes to FLUSH.
- FLUSH: arr_en=0, one cycle; samples the scores from the last step. Then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE. The best_* outputs hold until the next accepted start.
- Score tracking:
  - The cycle after each arr_en step t (0-based), PE i is sampled iff i<Q and 0≤t−i<R.
  - Scores are unsigned.
  - Strictly greater replaces the best. On ties the earlier step is kept; within a step, the lowest i wins.
  - best_qpos=i, best_rpos=t−i.
- start outside IDLE is ignored. busy=1 in every state except IDLE.

## Timing
- Reset values:
  - State IDLE, arr_clr=1, all other outputs 0.
  - arr_qry is all 3'b111.
  - arr_clr=0 from the first cycle after reset deasserts.
- Reset mid-operation: in the next cycle all outputs take their reset values, and any partial result is discarded.
- Stall-free run with start at cycle 0:
  - LOAD_Q: cycles 1..Q.
  - CLEAR: cycle Q+1.
  - Steps: cycles Q+2..2Q+R, which is Q+R−1 steps.
  - FLUSH: cycle 2Q+R+1.
  - done: cycle 2Q+R+2.
- Each qry or ref stall cycle delays done by exactly one cycle.
- The array score sampled for step t is arr_score in the cycle after that step's arr_en.
- Error path: err and done are both asserted in the cycle after start.

## Test plan
- Q=4 query {0,1,2,3}, R=4 identical reference, no stalls → best_score=8, best_qpos=3, best_rpos=3, done at cycle 14.
- Q=4 query {0,0,0,0}, R=4 reference {1,1,1,1} → best_score=0, best_qpos=0, best_rpos=0, arr_en high for exactly 7 cycles.
- Same as test 1 with ref_valid low for 3 cycles after the 2nd base → identical results, done at cycle 17, arr_en low during the stall.
- qry_len=0 (then repeat with ref_len=0) → err=1 and done=1 at cycle 1, qry_ready never asserted, best_score=0.
- Reset driven low for one cycle mid-STREAM → next cycle: busy=0, arr_clr=1, best_score=0. A following start runs normally.
- start pulsed during DRAIN → ignored; exactly one done pulse; results match a clean run.
